// File: rtl/bist_tpg.sv
// LFSR test pattern generator and scan sequencer feeding the CUT scan chain and the MISR.
// Define TPG_RESEED_EN to add seed_load/seed_in for a loadable run seed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start after reset
// ST_SHIFT  | shifting CHAIN_LEN pseudo-random bits into the chain
// ST_CAPTURE| one-cycle capture strobe, new primary inputs applied
// ST_FLUSH  | shifting zeros to unload the final response into the MISR
// ST_DONE   | run complete, done held until next start or reset

module bist_tpg #(
    parameter int          CHAIN_LEN    = 32,
    parameter int          NUM_PATTERNS = 256,
    parameter int          PI_BITS      = 8,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
`ifdef TPG_RESEED_EN
    input  logic                              seed_load,
    input  logic [15:0]                       seed_in,
`endif
    output logic                              scan_in,
    output logic                              scan_en,
    output logic                              capture,
    output logic [PI_BITS-1:0]                pi_data,
    output logic                              misr_en,
    output logic                              misr_clear,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(NUM_PATTERNS+1)-1:0] pattern_cnt
);

    localparam int PCW = $clog2(NUM_PATTERNS + 1);
    localparam int TW  = $clog2(CHAIN_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t          state, state_d;
    logic [15:0]     lfsr, lfsr_d;
    logic [TW-1:0]   tmr, tmr_d;
    logic [PCW-1:0]  pcnt_d;
    logic            start_run;
`ifdef TPG_RESEED_EN
    logic [15:0]     run_seed, run_seed_d;
`endif

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // The all-zero state would lock the LFSR, so it is never loaded.
    function automatic logic [15:0] non_zero(input logic [15:0] v);
        return (v == 16'h0000) ? SEED : v;
    endfunction

    always_comb begin
        state_d   = state;
        lfsr_d    = lfsr;
        tmr_d     = tmr;
        pcnt_d    = pattern_cnt;
        start_run = 1'b0;
`ifdef TPG_RESEED_EN
        run_seed_d = run_seed;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
`ifdef TPG_RESEED_EN
                if (seed_load) begin
                    run_seed_d = non_zero(seed_in);
                    lfsr_d     = run_seed_d;
                end
`endif
                if (start) begin
                    state_d   = ST_SHIFT;
`ifdef TPG_RESEED_EN
                    lfsr_d    = run_seed_d;
`else
                    lfsr_d    = non_zero(SEED);
`endif
                    tmr_d     = TW'(CHAIN_LEN - 1);
                    pcnt_d    = '0;
                    start_run = 1'b1;
                end
            end
            ST_SHIFT: begin
                lfsr_d = lfsr_step(lfsr);
                if (tmr == '0) state_d = ST_CAPTURE;
                else           tmr_d   = tmr - TW'(1);
            end
            ST_CAPTURE: begin
                pcnt_d  = pattern_cnt + PCW'(1);
                tmr_d   = TW'(CHAIN_LEN - 1);
                state_d = (pcnt_d == PCW'(NUM_PATTERNS)) ? ST_FLUSH : ST_SHIFT;
            end
            ST_FLUSH: begin
                if (tmr == '0) state_d = ST_DONE;
                else           tmr_d   = tmr - TW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-cycle state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            lfsr        <= SEED;
            tmr         <= '0;
            pattern_cnt <= '0;
            scan_in     <= 1'b0;
            scan_en     <= 1'b0;
            capture     <= 1'b0;
            pi_data     <= '0;
            misr_en     <= 1'b0;
            misr_clear  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef TPG_RESEED_EN
            run_seed    <= SEED;
`endif
        end else begin
            state       <= state_d;
            lfsr        <= lfsr_d;
            tmr         <= tmr_d;
            pattern_cnt <= pcnt_d;
            scan_in     <= (state_d == ST_SHIFT) & lfsr_d[15];
            scan_en     <= (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
            capture     <= (state_d == ST_CAPTURE);
            if (state_d == ST_CAPTURE) pi_data <= lfsr_d[PI_BITS-1:0];
            // The first load only unloads stale chain contents, so it is not compacted.
            misr_en     <= ((state_d == ST_SHIFT) && (pcnt_d != '0)) || (state_d == ST_FLUSH);
            misr_clear  <= start_run;
            busy        <= (state_d == ST_SHIFT) || (state_d == ST_CAPTURE) ||
                           (state_d == ST_FLUSH);
            done        <= (state_d == ST_DONE);
`ifdef TPG_RESEED_EN
            run_seed    <= run_seed_d;
`endif
        end
    end

endmodule

// File: tb/tb_bist_tpg.sv
// Scoreboard bench for bist_tpg: stimulus pushes expected per-cycle beats, a monitor pops and compares.
module tb_bist_tpg;

    localparam int          CL  = 4;
    localparam int          NP  = 2;
    localparam int          PB  = 8;
    localparam logic [15:0] SD  = 16'hACE1;
    localparam int          PCW = $clog2(NP + 1);

    logic            clock, reset, start;
    logic            scan_in, scan_en, capture, misr_en, misr_clear, busy, done;
    logic [PB-1:0]   pi_data;
    logic [PCW-1:0]  pattern_cnt;
`ifdef TPG_RESEED_EN
    logic            seed_load;
    logic [15:0]     seed_in;
`endif

    bist_tpg #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .PI_BITS(PB), .SEED(SD)) dut (
        .clock(clock), .reset(reset), .start(start),
`ifdef TPG_RESEED_EN
        .seed_load(seed_load), .seed_in(seed_in),
`endif
        .scan_in(scan_in), .scan_en(scan_en), .capture(capture), .pi_data(pi_data),
        .misr_en(misr_en), .misr_clear(misr_clear), .busy(busy), .done(done),
        .pattern_cnt(pattern_cnt)
    );

    typedef struct packed {
        logic           si, se, cap, me, mc, bz, dn;
        logic [PB-1:0]  pi;
        logic [PCW-1:0] pc;
        logic           pc_chk;
    } beat_t;

    beat_t          sb_q[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [PB-1:0]  model_pi = '0;
    logic           hand_chk = 1'b1;
    logic           done_q   = 1'b0;
    int             busy_idx = 0;
    int             cap_no   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic push_beat(input beat_t b, inout int n, input int limit);
        if (n < limit) sb_q.push_back(b);
        n++;
    endtask

    // Expected stream of one run: NP x (CL shift + 1 capture), CL flush, then the first done cycle.
    task automatic push_run(input logic [15:0] seed, input int limit);
        logic [15:0] l;
        beat_t       b;
        int          n;
        l = seed;
        n = 0;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < CL; i++) begin
                b = '0;
                b.si = l[15]; b.se = 1'b1; b.me = (p > 0); b.mc = (p == 0 && i == 0);
                b.bz = 1'b1; b.pi = model_pi; b.pc = PCW'(p); b.pc_chk = 1'b1;
                push_beat(b, n, limit);
                l = lfsr_next(l);
            end
            model_pi = l[PB-1:0];
            b = '0;
            b.cap = 1'b1; b.bz = 1'b1; b.pi = model_pi; b.pc_chk = 1'b0;
            push_beat(b, n, limit);
        end
        for (int i = 0; i < CL; i++) begin
            b = '0;
            b.se = 1'b1; b.me = 1'b1; b.bz = 1'b1; b.pi = model_pi; b.pc = PCW'(NP); b.pc_chk = 1'b1;
            push_beat(b, n, limit);
        end
        b = '0;
        b.dn = 1'b1; b.pi = model_pi; b.pc = PCW'(NP); b.pc_chk = 1'b1;
        push_beat(b, n, limit);
    endtask

    always @(negedge clock) begin
        beat_t a, e;
        logic  ok;
        a = '0;
        a.si = scan_in; a.se = scan_en; a.cap = capture; a.me = misr_en; a.mc = misr_clear;
        a.bz = busy; a.dn = done; a.pi = pi_data; a.pc = pattern_cnt;
        if (busy === 1'b1 || (done === 1'b1 && done_q !== 1'b1)) begin
            if (busy === 1'b1) busy_idx++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got beat %h with no expectation at %0t", a, $time);
            end else begin
                e  = sb_q.pop_front();
                ok = ({a.si, a.se, a.cap, a.me, a.mc, a.bz, a.dn, a.pi} ===
                      {e.si, e.se, e.cap, e.me, e.mc, e.bz, e.dn, e.pi}) &&
                     (!e.pc_chk || a.pc === e.pc);
                n_checks++;
                if (ok) n_pass++;
                else $display("FAIL beat%0d: got si%b se%b cap%b me%b mc%b bz%b dn%b pi%h pc%0d expected si%b se%b cap%b me%b mc%b bz%b dn%b pi%h pc%0d",
                              busy_idx, a.si, a.se, a.cap, a.me, a.mc, a.bz, a.dn, a.pi, a.pc,
                              e.si, e.se, e.cap, e.me, e.mc, e.bz, e.dn, e.pi, e.pc);
            end
            if (hand_chk && busy === 1'b1) begin
                if (busy_idx == 1) chk("first_scan_bit", 32'(scan_in), 32'd1);
                if (busy_idx == 2) chk("second_scan_bit", 32'(scan_in), 32'd0);
                if (capture === 1'b1) begin
                    chk("capture_cycle", 32'(busy_idx), (cap_no == 0) ? 32'd5 : 32'd10);
                    chk("capture_pi", 32'(pi_data), (cap_no == 0) ? 32'h1E : 32'hE4);
                    cap_no++;
                end
                chk("misr_window", 32'(misr_en),
                    32'((busy_idx >= 6 && busy_idx <= 9) || (busy_idx >= 11 && busy_idx <= 14)));
            end
            if (busy !== 1'b1) begin
                chk("busy_length", 32'(busy_idx), 32'd14);
                busy_idx = 0;
                cap_no   = 0;
            end
        end else begin
            busy_idx = 0;
            cap_no   = 0;
        end
        done_q = done;
    end

    task automatic check_idle(input string name);
        chk(name, 32'({scan_in, scan_en, capture, pi_data, misr_en, misr_clear, busy, done, pattern_cnt}), 32'd0);
    endtask

    task automatic pulse_start;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", 32'(done === 1'b1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef TPG_RESEED_EN
        seed_load = 1'b0;
        seed_in   = 16'h0000;
`endif
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check_idle("reset_idle");
        end

        // Basic run from IDLE.
        push_run(SD, 1000);
        pulse_start();
        wait_done();

        // Restart from DONE with start pulses during SHIFT and FLUSH that must be ignored.
        push_run(SD, 1000);
        pulse_start();
        repeat (2) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (8) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done();

        // Reset during the second SHIFT phase, then a fresh identical run.
        push_run(SD, 7);
        pulse_start();
        repeat (6) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle("reset_midrun");
        @(posedge clock);
        #1 reset = 1'b0;
        model_pi = '0;
        push_run(SD, 1000);
        pulse_start();
        wait_done();

`ifdef TPG_RESEED_EN
        // Seed 0x0001: first scan bit is 0.
        hand_chk = 1'b0;
        @(posedge clock); #1 seed_load = 1'b1; seed_in = 16'h0001;
        @(posedge clock); #1 seed_load = 1'b0;
        push_run(16'h0001, 1000);
        pulse_start();
        wait_done();

        // Seed 0 loaded together with start falls back to SEED; a busy seed_load is ignored.
        hand_chk = 1'b1;
        push_run(SD, 1000);
        @(posedge clock); #1 seed_load = 1'b1; seed_in = 16'h0000; start = 1'b1;
        @(posedge clock); #1 seed_load = 1'b0; start = 1'b0;
        repeat (2) @(posedge clock);
        #1 seed_load = 1'b1; seed_in = 16'h0001;
        @(posedge clock); #1 seed_load = 1'b0;
        wait_done();

        push_run(SD, 1000);
        pulse_start();
        wait_done();
`endif

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
